issue_rat_freelist_banked: RTL and testbench
============================================

# issue_rat_freelist_banked

Parametrised banked free list for physical register file (PRF) tags, serving the issue-stage register alias table. The block holds every free PRF tag in `BANK_COUNT` circular FIFO banks; bank index = low bits of the tag. It accepts returned tags on two ports: redeemed (priority), and abandoned (through a 1-entry skid buffer). It hands out one tag per cycle, round-robin across banks, and exports a registered free count with a low-watermark flag.

## Interface
- `PRF_COUNT`, default 64: total PRF tags. Power of two, ≥ 2·`BANK_COUNT`.
- `BANK_COUNT`, default 2: number of banks. Power of two, ≥ 2. Per-bank depth = `PRF_COUNT`/`BANK_COUNT`.
- `LOW_WATERMARK`, default 4: `o_low_water` threshold.
- Derived: `PW` = log2(`PRF_COUNT`) is the tag width. `BW` = log2(`BANK_COUNT`).

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_redeemed_prf`  in  PW  returned tag, redeem port.
- `i_redeemed_valid`  in  1  redeem request.
- `o_redeemed_ready`  out  1  redeem accepted this cycle.
- `i_abandoned_prf`  in  PW  returned tag, abandon port.
- `i_abandoned_valid`  in  1  abandon request.
- `o_abandoned_ready`  out  1  abandon accepted this cycle (direct or buffered).
- `o_acquire_prf`  out  PW  tag offered.
- `o_acquire_valid`  out  1  any bank non-empty.
- `i_acquire_ready`  in  1  consumer takes the offered tag.
- `o_free_count`  out  PW+1  tags held in banks. The skid buffer is excluded.
- `o_low_water`  out  1  `o_free_count` ≤ `LOW_WATERMARK`.

## Operation
- **Home bank.** Home bank of tag t = t[BW-1:0]. Tags are written only to their home bank.
- **Reset contents.** Bank b is full, holding b, b+`BANK_COUNT`, b+2·`BANK_COUNT`, … in ascending order from head.
- **Bank FIFO.** Each bank has read pointer, write pointer and occupancy count. Pointers wrap modulo depth. At most one write and one read per bank per cycle.
- **Per-bank write arbitration**, fixed priority:
  1. redeem request;
  2. skid-buffer entry;
  3. direct abandon.
  - A candidate is eligible only if its home bank is not full, using the registered count.
  - Up to `BANK_COUNT` writes per cycle, but only 3 sources exist.
- **Redeem handshake.** `o_redeemed_ready` = `i_redeemed_valid` & home bank not full.
- **Skid buffer.**
  - Drains when it wins its bank.
  - `buf_free` = buffer empty OR draining this cycle.
- **Abandon handshake.**
  - `o_abandoned_ready` = `i_abandoned_valid` & (direct write wins its bank OR `buf_free`).
  - Direct write takes precedence over loading the buffer.
  - Buffer loads only when `i_abandoned_valid` and the direct write lost.
- **Full home bank.** A tag whose home bank is full is never accepted. This indicates an illegal duplicate return; ready stays low and no state changes.
- **Acquire.**
  - Round-robin pointer `rr` (BW bits, reset 0).
  - Selected bank = first non-empty bank scanning `rr`, `rr`+1, … modulo `BANK_COUNT`.
  - `o_acquire_prf` = head of the selected bank; `o_acquire_valid` = OR of bank non-empty flags.
  - On valid & ready: pop the selected bank; `rr` ← selected+1 mod `BANK_COUNT`.
  - `o_acquire_valid` does not depend on `i_acquire_ready`.
- **Free count.** `o_free_count` ← `o_free_count` + (bank writes this cycle) − (pop this cycle), registered.
- **Low water.** `o_low_water` is a combinational compare of the registered count.
- **Same-bank push and pop.** Both are allowed in one cycle when the bank is non-empty and not full. A push into an empty bank is not poppable until the next cycle (no bypass).

## Timing
- **Reset values:**
  - `o_acquire_valid`=1, `o_acquire_prf`=0;
  - `o_free_count`=`PRF_COUNT`, `o_low_water`=0;
  - both ready outputs = 0 unless valid inputs are present (combinational).
  - All state is reset asynchronously; assertion mid-operation restores the reset contents immediately, discarding the skid buffer and any in-flight tags.
- **Ready paths.** Ready outputs are combinational from valids, tags and registered state. There is no combinational path from `i_acquire_ready` to any ready output.
- **Return latency.** A tag accepted in cycle N is visible at a bank head, and counted, from cycle N+1. A buffered tag becomes visible one cycle after it drains.
- **Acquire latency.** Pop is effective in the same cycle as the handshake; the next head is offered in cycle N+1.
- **Throughput.** 1 acquire per cycle. Up to 2 bank writes per cycle (redeem + buffer/direct to different banks).

## Test plan
- **Reset drain.** Defaults, reset then `i_acquire_ready`=1 for 64 cycles → tags 0,1,2,…,63 in order. Afterwards `o_acquire_valid`=0 and `o_free_count`=0. `o_low_water` rises in the cycle `o_free_count` reaches 4.
- **Same-bank conflict.** After drain, redeem 6 and abandon 10 in the same cycle → both ready=1. Count goes 1 next cycle, 2 the cycle after. Acquires then return 6 then 10.
- **Different banks.** After drain, redeem 6 and abandon 7 in the same cycle → both direct. `o_free_count` +2 next cycle. Acquire returns 6 then 7 (`rr`=0).
- **Buffer backpressure.**
  - C1: redeem 4 + abandon 8 → 8 buffered.
  - C2: redeem 12 + abandon 14 → abandon ready=0.
  - C3: abandon 14 only → buffer drains 8, 14 buffered, ready=1.
  - C4: 14 drains.
- **Illegal duplicate.** At reset (banks full), redeem 2 → `o_redeemed_ready`=0, `o_free_count` stays 64.
- **Reset mid-stream.** Pulse `reset` asynchronously between clock edges after 10 pops with a buffered abandon → outputs immediately return to reset values. Next acquire yields 0.

Source files
------------

// File: rtl/issue_rat_freelist_banked.sv
// issue_rat_freelist_banked
//   Banked free list of physical register file tags for the issue-stage RAT.
//   Free tags live in BANK_COUNT circular FIFOs; a tag's home bank is its low
//   BW bits. Returned tags arrive on a redeem port (highest priority) and an
//   abandon port (direct write or a 1-entry skid buffer). One tag per cycle is
//   handed out, round-robin across non-empty banks.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   i_redeemed_*        returned tag, redeem port (valid/ready)
//   i_abandoned_*       returned tag, abandon port (valid/ready)
//   o_acquire_*         offered tag (valid), consumed by i_acquire_ready
//   o_free_count        registered count of tags held in the banks
//   o_low_water         o_free_count <= LOW_WATERMARK
module issue_rat_freelist_banked #(
   parameter  int PRF_COUNT     = 64,
   parameter  int BANK_COUNT    = 2,
   parameter  int LOW_WATERMARK = 4,
   localparam int PW            = $clog2(PRF_COUNT),
   localparam int BW            = $clog2(BANK_COUNT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [PW-1:0] i_redeemed_prf,
   input  logic          i_redeemed_valid,
   output logic          o_redeemed_ready,
   input  logic [PW-1:0] i_abandoned_prf,
   input  logic          i_abandoned_valid,
   output logic          o_abandoned_ready,
   output logic [PW-1:0] o_acquire_prf,
   output logic          o_acquire_valid,
   input  logic          i_acquire_ready,
   output logic [PW:0]   o_free_count,
   output logic          o_low_water
);

   localparam int DEPTH = PRF_COUNT / BANK_COUNT;
   localparam int DW    = $clog2(DEPTH);
   localparam int CW    = DW + 1;
   localparam int FW    = PW + 1;

   // bank storage and per-bank FIFO state
   logic [PW-1:0] mem_q   [BANK_COUNT][DEPTH];
   logic [DW-1:0] rd_q    [BANK_COUNT];
   logic [DW-1:0] rd_d    [BANK_COUNT];
   logic [DW-1:0] wr_q    [BANK_COUNT];
   logic [DW-1:0] wr_d    [BANK_COUNT];
   logic [CW-1:0] cnt_q   [BANK_COUNT];
   logic [CW-1:0] cnt_d   [BANK_COUNT];
   logic [PW-1:0] wr_tag  [BANK_COUNT];

   logic [BW-1:0] rr_q, rr_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          buf_vld_q, buf_vld_d;
   logic [PW-1:0] buf_tag_q, buf_tag_d;

   logic [BANK_COUNT-1:0] full, empty, wr_en, pop_en;
   logic [BW-1:0]         red_bank, ab_bank, buf_bank, sel;
   logic                  red_win, buf_win, ab_ok, ab_win, buf_free, buf_load;
   logic                  found, pop;
   logic [1:0]            nwr;

   // bank status from registered counts only, so ready never sees this cycle's pop
   always_comb begin
      for (int b = 0; b < BANK_COUNT; b++) begin
         full[b]  = (cnt_q[b] == CW'(DEPTH));
         empty[b] = (cnt_q[b] == '0);
      end
   end

   // write arbitration: redeem > skid buffer > direct abandon, per home bank
   always_comb begin
      red_bank = i_redeemed_prf[BW-1:0];
      ab_bank  = i_abandoned_prf[BW-1:0];
      buf_bank = buf_tag_q[BW-1:0];

      red_win  = i_redeemed_valid && !full[red_bank];
      buf_win  = buf_vld_q && !full[buf_bank] &&
                 !(red_win && (red_bank == buf_bank));
      // a full home bank means a duplicate return: never accept, not even into the buffer
      ab_ok    = i_abandoned_valid && !full[ab_bank];
      ab_win   = ab_ok && !(red_win && (red_bank == ab_bank)) &&
                 !(buf_win && (buf_bank == ab_bank));
      buf_free = !buf_vld_q || buf_win;
      buf_load = ab_ok && !ab_win && buf_free;

      o_redeemed_ready  = red_win;
      o_abandoned_ready = ab_ok && (ab_win || buf_free);
   end

   // round-robin acquire select: first non-empty bank starting at rr
   always_comb begin
      sel   = rr_q;
      found = 1'b0;
      for (int k = 0; k < BANK_COUNT; k++) begin
         if (!found && !empty[rr_q + BW'(k)]) begin
            sel   = rr_q + BW'(k);
            found = 1'b1;
         end
      end
      o_acquire_valid = |(~empty);
      o_acquire_prf   = mem_q[sel][rd_q[sel]];
      pop             = o_acquire_valid && i_acquire_ready;
      rr_d            = pop ? sel + BW'(1) : rr_q;
   end

   // per-bank next state
   always_comb begin
      for (int b = 0; b < BANK_COUNT; b++) begin
         wr_en[b]  = 1'b0;
         wr_tag[b] = '0;
         if (red_win && (red_bank == BW'(b))) begin
            wr_en[b]  = 1'b1;
            wr_tag[b] = i_redeemed_prf;
         end else if (buf_win && (buf_bank == BW'(b))) begin
            wr_en[b]  = 1'b1;
            wr_tag[b] = buf_tag_q;
         end else if (ab_win && (ab_bank == BW'(b))) begin
            wr_en[b]  = 1'b1;
            wr_tag[b] = i_abandoned_prf;
         end
         pop_en[b] = pop && (sel == BW'(b));
         wr_d[b]   = wr_q[b] + DW'(wr_en[b]);
         rd_d[b]   = rd_q[b] + DW'(pop_en[b]);
         cnt_d[b]  = cnt_q[b] + CW'(wr_en[b]) - CW'(pop_en[b]);
      end
   end

   // skid buffer and free count
   always_comb begin
      buf_vld_d = buf_vld_q;
      buf_tag_d = buf_tag_q;
      if (buf_win) buf_vld_d = 1'b0;
      if (buf_load) begin
         buf_vld_d = 1'b1;
         buf_tag_d = i_abandoned_prf;
      end
      nwr    = {1'b0, red_win} + {1'b0, buf_win} + {1'b0, ab_win};
      fcnt_d = fcnt_q + FW'(nwr) - FW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // every bank starts full: b, b+BANK_COUNT, ... ascending from head
         for (int b = 0; b < BANK_COUNT; b++) begin
            for (int i = 0; i < DEPTH; i++) mem_q[b][i] <= PW'(b + i * BANK_COUNT);
            rd_q[b]  <= '0;
            wr_q[b]  <= '0;
            cnt_q[b] <= CW'(DEPTH);
         end
         rr_q      <= '0;
         fcnt_q    <= FW'(PRF_COUNT);
         buf_vld_q <= 1'b0;
         buf_tag_q <= '0;
      end else begin
         for (int b = 0; b < BANK_COUNT; b++) begin
            if (wr_en[b]) mem_q[b][wr_q[b]] <= wr_tag[b];
            rd_q[b]  <= rd_d[b];
            wr_q[b]  <= wr_d[b];
            cnt_q[b] <= cnt_d[b];
         end
         rr_q      <= rr_d;
         fcnt_q    <= fcnt_d;
         buf_vld_q <= buf_vld_d;
         buf_tag_q <= buf_tag_d;
      end
   end

   assign o_free_count = fcnt_q;
   assign o_low_water  = (fcnt_q <= FW'(LOW_WATERMARK));

endmodule

// File: tb/tb_issue_rat_freelist_banked.sv
// Bench for issue_rat_freelist_banked: a queue-based model of the free list is
// checked against the DUT every cycle, plus literal expectations for the
// directed scenarios.
module tb_issue_rat_freelist_banked;

   localparam int NB    = 2;
   localparam int PRF   = 64;
   localparam int DEPTH = PRF / NB;
   localparam int LOWW  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] i_redeemed_prf, i_abandoned_prf, o_acquire_prf;
   logic       i_redeemed_valid, o_redeemed_ready;
   logic       i_abandoned_valid, o_abandoned_ready;
   logic       o_acquire_valid, i_acquire_ready, o_low_water;
   logic [6:0] o_free_count;

   int nchk = 0;
   int nfail = 0;

   // model state
   int bq [NB][$];
   bit buf_v;
   int buf_t;
   int rr;
   int got[$];
   // outputs captured at the last sample point
   int c_rr, c_ar, c_av, c_cnt, c_low;

   issue_rat_freelist_banked #(.PRF_COUNT(PRF), .BANK_COUNT(NB), .LOW_WATERMARK(LOWW)) dut (
      .clk               (clk),
      .reset             (reset),
      .i_redeemed_prf    (i_redeemed_prf),
      .i_redeemed_valid  (i_redeemed_valid),
      .o_redeemed_ready  (o_redeemed_ready),
      .i_abandoned_prf   (i_abandoned_prf),
      .i_abandoned_valid (i_abandoned_valid),
      .o_abandoned_ready (o_abandoned_ready),
      .o_acquire_prf     (o_acquire_prf),
      .o_acquire_valid   (o_acquire_valid),
      .i_acquire_ready   (i_acquire_ready),
      .o_free_count      (o_free_count),
      .o_low_water       (o_low_water)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      for (int b = 0; b < NB; b++) begin
         bq[b].delete();
         for (int i = 0; i < DEPTH; i++) bq[b].push_back(b + i * NB);
      end
      buf_v = 1'b0;
      buf_t = 0;
      rr    = 0;
   endtask

   // compare DUT against model for this cycle, then advance the model
   task automatic model_step();
      int rb, ab, bb, sel, cnt, idx;
      bit r_acc, b_drain, a_dir, a_acc, av;
      rb = int'(i_redeemed_prf) % NB;
      ab = int'(i_abandoned_prf) % NB;
      bb = buf_t % NB;
      r_acc   = i_redeemed_valid && (bq[rb].size() < DEPTH);
      b_drain = buf_v && (bq[bb].size() < DEPTH) && !(r_acc && rb == bb);
      a_dir   = i_abandoned_valid && (bq[ab].size() < DEPTH) &&
                !(r_acc && rb == ab) && !(b_drain && bb == ab);
      a_acc   = i_abandoned_valid && (bq[ab].size() < DEPTH) && (a_dir || !buf_v || b_drain);
      cnt = 0;
      for (int b = 0; b < NB; b++) cnt += bq[b].size();
      av  = 1'b0;
      sel = rr;
      for (int k = 0; k < NB; k++) begin
         idx = (rr + k) % NB;
         if (!av && bq[idx].size() > 0) begin
            sel = idx;
            av  = 1'b1;
         end
      end
      chk("redeemed_ready", int'(o_redeemed_ready), int'(r_acc));
      chk("abandoned_ready", int'(o_abandoned_ready), int'(a_acc));
      chk("acquire_valid", int'(o_acquire_valid), int'(av));
      if (av) chk("acquire_prf", int'(o_acquire_prf), bq[sel][0]);
      chk("free_count", int'(o_free_count), cnt);
      chk("low_water", int'(o_low_water), int'(cnt <= LOWW));
      c_rr  = int'(o_redeemed_ready);
      c_ar  = int'(o_abandoned_ready);
      c_av  = int'(o_acquire_valid);
      c_cnt = int'(o_free_count);
      c_low = int'(o_low_water);
      if (o_acquire_valid && i_acquire_ready) got.push_back(int'(o_acquire_prf));
      if (av && i_acquire_ready) begin
         void'(bq[sel].pop_front());
         rr = (sel + 1) % NB;
      end
      if (r_acc) bq[rb].push_back(int'(i_redeemed_prf));
      if (b_drain) begin
         bq[bb].push_back(buf_t);
         buf_v = 1'b0;
      end
      if (a_dir) bq[ab].push_back(int'(i_abandoned_prf));
      if (a_acc && !a_dir) begin
         buf_v = 1'b1;
         buf_t = int'(i_abandoned_prf);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!reset) model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      i_redeemed_valid  = 1'b0;
      i_redeemed_prf    = '0;
      i_abandoned_valid = 1'b0;
      i_abandoned_prf   = '0;
      i_acquire_ready   = 1'b0;
   endtask

   task automatic ret(bit rv, int rp, bit av, int ap);
      i_redeemed_valid  = rv;
      i_redeemed_prf    = 6'(rp);
      i_abandoned_valid = av;
      i_abandoned_prf   = 6'(ap);
   endtask

   task automatic chk_got(string name, int n, int e0, int e1, int e2, int e3);
      int exp [4];
      exp = '{e0, e1, e2, e3};
      chk({name, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], exp[i]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle();
      mdl_reset();
      @(posedge clk);
      #1;
      chk("rst_acquire_valid", int'(o_acquire_valid), 1);
      chk("rst_acquire_prf", int'(o_acquire_prf), 0);
      chk("rst_free_count", int'(o_free_count), 64);
      chk("rst_low_water", int'(o_low_water), 0);
      chk("rst_redeemed_ready", int'(o_redeemed_ready), 0);
      chk("rst_abandoned_ready", int'(o_abandoned_ready), 0);
      reset = 1'b0;

      // duplicate returns into full banks are refused
      ret(1, 2, 1, 5);
      tick();
      chk("dup_redeemed_ready", c_rr, 0);
      chk("dup_abandoned_ready", c_ar, 0);
      idle();
      tick();
      chk("dup_free_count", c_cnt, 64);

      // drain everything in tag order
      got.delete();
      i_acquire_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (i == 59) chk("low_water_at_5", c_low, 0);
         if (i == 60) chk("low_water_at_4", c_low, 1);
      end
      tick();
      chk("drained_valid", c_av, 0);
      chk("drained_count", c_cnt, 0);
      chk("drain_total", got.size(), 64);
      for (int i = 0; i < got.size(); i++) chk("drain_order", got[i], i);

      // different banks: both direct, rr back at 0
      idle();
      ret(1, 6, 1, 7);
      tick();
      chk("diff_redeemed_ready", c_rr, 1);
      chk("diff_abandoned_ready", c_ar, 1);
      idle();
      tick();
      chk("diff_count", c_cnt, 2);
      got.delete();
      i_acquire_ready = 1'b1;
      tick();
      tick();
      idle();
      chk_got("diff_order", 2, 6, 7, 0, 0);

      // same bank: abandon goes through the skid buffer
      ret(1, 6, 1, 10);
      tick();
      chk("same_redeemed_ready", c_rr, 1);
      chk("same_abandoned_ready", c_ar, 1);
      idle();
      tick();
      chk("same_count_1", c_cnt, 1);
      tick();
      chk("same_count_2", c_cnt, 2);
      got.delete();
      i_acquire_ready = 1'b1;
      tick();
      tick();
      idle();
      chk_got("same_order", 2, 6, 10, 0, 0);

      // buffer backpressure
      ret(1, 4, 1, 8);
      tick();
      chk("c1_redeemed_ready", c_rr, 1);
      chk("c1_abandoned_ready", c_ar, 1);
      ret(1, 12, 1, 14);
      tick();
      chk("c2_redeemed_ready", c_rr, 1);
      chk("c2_abandoned_ready", c_ar, 0);
      chk("c2_count", c_cnt, 1);
      ret(0, 0, 1, 14);
      tick();
      chk("c3_abandoned_ready", c_ar, 1);
      chk("c3_count", c_cnt, 2);
      idle();
      tick();
      chk("c4_count", c_cnt, 3);
      tick();
      chk("c5_count", c_cnt, 4);
      got.delete();
      i_acquire_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      idle();
      chk_got("bp_order", 4, 4, 12, 8, 14);

      // reset mid-stream with a buffered abandon
      reset = 1'b1;
      #1;
      reset = 1'b0;
      mdl_reset();
      i_acquire_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      idle();
      ret(1, 0, 1, 2);
      tick();
      chk("mid_redeemed_ready", c_rr, 1);
      chk("mid_abandoned_ready", c_ar, 1);
      idle();
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", int'(o_acquire_valid), 1);
      chk("mid_rst_prf", int'(o_acquire_prf), 0);
      chk("mid_rst_count", int'(o_free_count), 64);
      chk("mid_rst_low", int'(o_low_water), 0);
      reset = 1'b0;
      mdl_reset();
      got.delete();
      i_acquire_ready = 1'b1;
      tick();
      idle();
      chk_got("post_rst_first", 1, 0, 0, 0, 0);
      tick();
      chk("post_rst_count", c_cnt, 63);
      tick();
      chk("post_rst_count_hold", c_cnt, 63);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
